// File: rtl/crossbar_pkg.sv
// Shared AXI4-Lite types and constants for the crossbar and its targets.
// The response code is a single bit: OKAY or SLVERR.
package crossbar;

    localparam int AXIL_ADDR_W = 64;
    localparam int AXIL_DATA_W = 64;
    localparam int AXIL_STRB_W = 8;

    localparam logic AXIL_RESP_OKAY   = 1'b0;
    localparam logic AXIL_RESP_SLVERR = 1'b1;

    typedef enum logic {W_IDLE, W_RESP} axil_wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} axil_rd_state_t;

    typedef struct packed {
        logic                   awvalid;
        logic [AXIL_ADDR_W-1:0] awaddr;
        logic [2:0]             awprot;
        logic                   wvalid;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
        logic                   bready;
        logic                   arvalid;
        logic [AXIL_ADDR_W-1:0] araddr;
        logic [2:0]             arprot;
        logic                   rready;
    } axi4lite_MOSI_t;

    typedef struct packed {
        logic                   awready;
        logic                   wready;
        logic                   bvalid;
        logic                   bresp;
        logic                   arready;
        logic                   rvalid;
        logic [AXIL_DATA_W-1:0] rdata;
        logic                   rresp;
    } axi4lite_MISO_t;

endpackage

// File: rtl/axi4lite_strb_merge.sv
// Byte-strobe merge: each strobed byte takes the new value, the rest keep the old one.
module axi4lite_strb_merge
    import crossbar::*;
(
    input  logic [AXIL_DATA_W-1:0] old_data,
    input  logic [AXIL_DATA_W-1:0] new_data,
    input  logic [AXIL_STRB_W-1:0] strb,
    output logic [AXIL_DATA_W-1:0] merged_data
);

    // per-byte select between old and new data
    always_comb begin
        merged_data = old_data;
        for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (strb[b]) merged_data[8*b +: 8] = new_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank target: NUM_REGS x 64-bit registers with byte strobes.
// Optional macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead
// of aliasing modulo the bank size.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commit when both are present
// W_RESP | write committed, B response waiting for bready
// R_IDLE | ready for an AR
// R_RESP | read data registered, R response waiting for rready
module axi4lite_reg_slave
    import crossbar::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  axi4lite_MOSI_t            mosi,
    output axi4lite_MISO_t            miso,
    output logic [NUM_REGS*64-1:0]    regs_o
);

    localparam int          IDX_W = $clog2(NUM_REGS);
    localparam logic [63:0] SPAN  = 64'(NUM_REGS * 8);

    logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];

    axil_wr_state_t w_state_q, w_state_d;
    axil_rd_state_t r_state_q, r_state_d;

    logic                   aw_held_q, w_held_q;
    logic [AXIL_ADDR_W-1:0] aw_addr_q;
    logic [AXIL_DATA_W-1:0] w_data_q;
    logic [AXIL_STRB_W-1:0] w_strb_q;
    logic                   bresp_q, rresp_q;
    logic [AXIL_DATA_W-1:0] rdata_q;

    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
    logic [AXIL_ADDR_W-1:0] wr_addr, wr_off, rd_off;
    logic [AXIL_DATA_W-1:0] wr_data, wr_merged;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic                   wr_err, rd_err;
    logic                   unused_bits;

    // handshakes, commit condition and address decode
    always_comb begin
        aw_hs     = mosi.awvalid && miso.awready;
        w_hs      = mosi.wvalid  && miso.wready;
        b_hs      = miso.bvalid  && mosi.bready;
        ar_hs     = mosi.arvalid && miso.arready;
        r_hs      = miso.rvalid  && mosi.rready;
        wr_commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_addr   = aw_held_q ? aw_addr_q : mosi.awaddr;
        wr_data   = w_held_q  ? w_data_q  : mosi.wdata;
        wr_strb   = w_held_q  ? w_strb_q  : mosi.wstrb;
        wr_off    = wr_addr - BASE_ADDR;
        rd_off    = mosi.araddr - BASE_ADDR;
        wr_idx    = wr_off[IDX_W+2:3];
        rd_idx    = rd_off[IDX_W+2:3];
`ifdef AXIL_REG_SLVERR_EN
        wr_err    = (wr_addr < BASE_ADDR) || (wr_off >= SPAN);
        rd_err    = (mosi.araddr < BASE_ADDR) || (rd_off >= SPAN);
`else
        wr_err    = 1'b0;
        rd_err    = 1'b0;
`endif
    end

    // protection bits and sub-word offset bits carry no meaning for this target
    assign unused_bits = ^{mosi.awprot, mosi.arprot, wr_off, rd_off, SPAN};

    axi4lite_strb_merge u_merge (
        .old_data    (regs_q[wr_idx]),
        .new_data    (wr_data),
        .strb        (wr_strb),
        .merged_data (wr_merged)
    );

    // FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // next state and channel outputs
    always_comb begin
        w_state_d    = w_state_q;
        r_state_d    = r_state_q;
        miso         = '0;
        miso.awready = (w_state_q == W_IDLE) && !aw_held_q;
        miso.wready  = (w_state_q == W_IDLE) && !w_held_q;
        miso.bvalid  = (w_state_q == W_RESP);
        miso.bresp   = bresp_q;
        miso.arready = (r_state_q == R_IDLE);
        miso.rvalid  = (r_state_q == R_RESP);
        miso.rdata   = rdata_q;
        miso.rresp   = rresp_q;
        case (w_state_q)
            W_IDLE:  if (wr_commit) w_state_d = W_RESP;
            W_RESP:  if (b_hs)      w_state_d = W_IDLE;
            default:                w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_RESP;
            R_RESP:  if (r_hs)  r_state_d = R_IDLE;
            default:            r_state_d = R_IDLE;
        endcase
    end

    // write path: hold AW/W until both are present, then merge into the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= AXIL_RESP_OKAY;
        end else if (wr_commit) begin
            if (!wr_err) regs_q[wr_idx] <= wr_merged;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bresp_q   <= wr_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= mosi.awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= mosi.wdata;
                w_strb_q <= mosi.wstrb;
            end
        end
    end

    // read path: data sampled on the AR edge sees the pre-write register value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= AXIL_RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_err ? '0 : regs_q[rd_idx];
            rresp_q <= rd_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
        end
    end

    // flatten the register bank for local hardware
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[64*i +: 64] = regs_q[i];
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave (default parameters). Expected B/R
// responses are queued when requests are driven and checked when the DUT responds.
module tb_axi4lite_reg_slave;
    import crossbar::*;

    localparam int          NREGS = 8;
    localparam logic [63:0] BASE  = 64'h0;
    localparam logic [63:0] RVAL  = 64'h0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    axi4lite_MOSI_t mosi;
    axi4lite_MISO_t miso;
    logic [NREGS*64-1:0] regs_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model [NREGS];
    logic        bq [$];
    logic [64:0] rq [$];

    axi4lite_reg_slave #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .RESET_VAL(RVAL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mosi   (mosi),
        .miso   (miso),
        .regs_o (regs_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [63:0] addr);
`ifdef AXIL_REG_SLVERR_EN
        return (addr >= BASE) && ((addr - BASE) < 64'(NREGS * 8));
`else
        return 1'b1;
`endif
    endfunction

    function automatic int idx_of(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - BASE) >> 3;
        return int'(off % NREGS);
    endfunction

    // queue the expected B response and update the reference bank
    task automatic expect_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int k;
        if (in_range(addr)) begin
            k = idx_of(addr);
            for (int b = 0; b < 8; b++) if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
            bq.push_back(1'b0);
        end else begin
            bq.push_back(1'b1);
        end
    endtask

    task automatic expect_read(input logic [63:0] addr);
        if (in_range(addr)) rq.push_back({1'b0, model[idx_of(addr)]});
        else                rq.push_back({1'b1, 64'h0});
    endtask

    task automatic drive_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        mosi.awvalid = 1'b1; mosi.awaddr = addr;
        mosi.wvalid  = 1'b1; mosi.wdata  = data; mosi.wstrb = strb;
        expect_write(addr, data, strb);
    endtask

    task automatic drive_read(input logic [63:0] addr);
        mosi.arvalid = 1'b1; mosi.araddr = addr;
        expect_read(addr);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        mosi.bready = 1'b1;
        mosi.rready = 1'b1;
        while ((miso.bvalid || miso.rvalid) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NREGS; i++) chk(tag, regs_o[64*i +: 64], model[i]);
    endtask

    // scoreboard: compare each response on the cycle its handshake completes
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && miso.bvalid && mosi.bready) begin
            if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else chk("bresp", 64'(miso.bresp), 64'(bq.pop_front()));
        end
        if (rst_n && miso.rvalid && mosi.rready) begin
            if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else begin
                e = rq.pop_front();
                chk("rresp", 64'(miso.rresp), 64'(e[64]));
                chk("rdata", miso.rdata, e[63:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, d;
        logic [7:0]  s;
        mosi = '0;
        for (int i = 0; i < NREGS; i++) model[i] = RVAL;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(miso.awready), 64'd1);
        chk("rst_wready",  64'(miso.wready),  64'd1);
        chk("rst_arready", 64'(miso.arready), 64'd1);
        chk("rst_bvalid",  64'(miso.bvalid),  64'd0);
        chk("rst_rvalid",  64'(miso.rvalid),  64'd0);
        chk("rst_rdata",   miso.rdata,        64'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("idle_awready", 64'(miso.awready), 64'd1);
        chk("idle_arready", 64'(miso.arready), 64'd1);
        check_bank("reset_bank");

        // AW and W together, then read back
        mosi.bready = 1'b1;
        drive_write(64'h10, 64'h1122334455667788, 8'hFF);
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        chk("b_latency", 64'(miso.bvalid), 64'd1);
        chk("busy_awready", 64'(miso.awready), 64'd0);
        tick();
        chk("b_done", 64'(miso.bvalid), 64'd0);
        mosi.rready = 1'b1;
        drive_read(64'h10);
        tick();
        mosi.arvalid = 1'b0;
        chk("r_latency", 64'(miso.rvalid), 64'd1);
        chk("r_arready", 64'(miso.arready), 64'd0);
        wait_idle();

        // W three cycles before AW; commit on the AW edge
        mosi.wvalid = 1'b1; mosi.wdata = 64'hAAAAAAAAAAAAAAAA; mosi.wstrb = 8'h0F;
        tick();
        mosi.wvalid = 1'b0;
        chk("w_held_wready", 64'(miso.wready), 64'd0);
        chk("w_held_awready", 64'(miso.awready), 64'd1);
        tick();
        tick();
        chk("w_only_no_b", 64'(miso.bvalid), 64'd0);
        mosi.awvalid = 1'b1; mosi.awaddr = 64'h10;
        expect_write(64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        tick();
        mosi.awvalid = 1'b0;
        chk("late_aw_b", 64'(miso.bvalid), 64'd1);
        chk("reg2_merge", regs_o[64*2 +: 64], 64'h11223344AAAAAAAA);
        wait_idle();

        // back-pressure on B holds the response and blocks a new AW/W
        mosi.bready = 1'b0;
        drive_write(64'h08, 64'h0123456789ABCDEF, 8'hFF);
        tick();
        drive_write(64'h20, 64'hFEDCBA9876543210, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid",  64'(miso.bvalid),  64'd1);
            chk("bp_bresp",   64'(miso.bresp),   64'd0);
            chk("bp_awready", 64'(miso.awready), 64'd0);
            chk("bp_wready",  64'(miso.wready),  64'd0);
            tick();
        end
        mosi.bready = 1'b1;
        tick();
        chk("bp_released", 64'(miso.bvalid), 64'd0);
        chk("bp_awready_back", 64'(miso.awready), 64'd1);
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        chk("bp_second_b", 64'(miso.bvalid), 64'd1);
        wait_idle();
        check_bank("bp_bank");

        // same-edge write and read of one register: read returns the old value
        drive_read(64'h18);
        drive_write(64'h18, 64'h5, 8'hFF);
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
        chk("same_edge_rvalid", 64'(miso.rvalid), 64'd1);
        wait_idle();
        drive_read(64'h18);
        tick();
        mosi.arvalid = 1'b0;
        wait_idle();

        // past the top of the bank: alias or SLVERR depending on build
        drive_write(64'h40, 64'h000000000000BEEF, 8'h03);
        tick();
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        wait_idle();
        check_bank("oor_bank");
        drive_read(64'h40);
        tick();
        mosi.arvalid = 1'b0;
        wait_idle();

        // random in-range traffic
        for (int i = 0; i < 6; i++) begin
            a = 64'($urandom_range(0, NREGS - 1)) << 3;
            d = {$urandom, $urandom};
            s = 8'($urandom_range(0, 255));
            drive_write(a, d, s);
            tick();
            mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
            wait_idle();
            drive_read(a);
            tick();
            mosi.arvalid = 1'b0;
            wait_idle();
        end
        check_bank("rand_bank");

        // reset with an AW held: everything discarded
        mosi.awvalid = 1'b1; mosi.awaddr = 64'h08;
        tick();
        mosi.awvalid = 1'b0;
        chk("held_awready", 64'(miso.awready), 64'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) model[i] = RVAL;
        chk("midrst_awready", 64'(miso.awready), 64'd1);
        check_bank("midrst_bank");
        #2 rst_n = 1'b1;
        tick();
        mosi.wvalid = 1'b1; mosi.wdata = 64'h00000000CAFEF00D; mosi.wstrb = 8'hFF;
        tick();
        mosi.wvalid = 1'b0;
        chk("midrst_no_b", 64'(miso.bvalid), 64'd0);
        mosi.awvalid = 1'b1; mosi.awaddr = 64'h08;
        expect_write(64'h08, 64'h00000000CAFEF00D, 8'hFF);
        tick();
        mosi.awvalid = 1'b0;
        chk("midrst_b", 64'(miso.bvalid), 64'd1);
        wait_idle();
        check_bank("final_bank");

        chk("bq_empty", 64'(bq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
- AXI4-Lite responder (slave endpoint) that terminates one crossbar output port.
- Consumes a `crossbar::axi4lite_MOSI_t` bundle and drives a `crossbar::axi4lite_MISO_t` bundle.
- Implements a bank of NUM_REGS 64-bit read/write registers with byte strobes.
- Exposes the register contents to local hardware; used as a target when bringing up and verifying the parametrized crossbar.

Parameters:
- NUM_REGS, 8, number of 64-bit registers; must be a power of two and at least 2.
- BASE_ADDR, 64'h0, byte address of register 0; must be aligned to NUM_REGS*8.
- RESET_VAL, 64'h0, reset value loaded into every register.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mosi  input  crossbar::axi4lite_MOSI_t  request channels (AW, W, B-ready, AR, R-ready).
- miso  output  crossbar::axi4lite_MISO_t  response channels (AW/W/AR ready, B, R).
- regs_o  output  NUM_REGS*64  flattened register contents; register i occupies bits [64*i+63:64*i].

Behaviour:
- Decode: off = addr - BASE_ADDR; idx = off[3+log2(NUM_REGS)-1:3].
  - off[2:0] ignored; awprot and arprot ignored.
- Reset values (while rst_n low):
  - every register = RESET_VAL; both FSMs in IDLE.
  - bvalid=0, rvalid=0, rdata=0, bresp=0, rresp=0.
  - awready=1, wready=1, arready=1.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE: awready = !aw_held; wready = !w_held.
  - AW handshake latches awaddr and sets aw_held. W handshake latches wdata/wstrb and sets w_held.
  - AW and W are accepted independently, in any order, including in the same cycle.
  - On the edge where the second of AW/W completes (or both together): for each byte b with wstrb[b]=1, reg[idx] byte b = wdata byte b; other bytes unchanged.
  - On that same edge: state -> W_RESP, bvalid=1, bresp=OKAY, held flags cleared.
  - Minimum latency: AW+W at edge N -> bvalid high after edge N.
  - In W_RESP: awready=0, wready=0; bvalid and bresp held stable until bready.
  - On the B handshake edge: bvalid=0, -> W_IDLE; readies return to 1 after that edge.
- Read FSM, states R_IDLE and R_RESP:
  - In R_IDLE arready=1. The AR handshake at edge N registers rdata=reg[idx], rvalid=1, rresp=OKAY, -> R_RESP.
  - In R_RESP: arready=0; rdata, rresp and rvalid held stable until rready.
  - On the R handshake edge: rvalid=0, -> R_IDLE. At most one read outstanding.
- Simultaneous events:
  - Read and write FSMs are fully independent.
  - A read and a write committing to the same register on the same edge: the read returns the pre-write value.
  - A B handshake and a new AW/W arriving in the same cycle: the new AW/W is not accepted (readies are 0 in W_RESP).
- Reset asserted mid-transaction: immediate return to reset values; held AW/W and pending responses are discarded.
- regs_o reflects committed register values one edge after the write commits.

Optional Feature:
- Macro: AXIL_REG_SLVERR_EN.
- Defined:
  - A request with addr < BASE_ADDR or off >= NUM_REGS*8 is out of range.
  - Out-of-range write: no register is modified; bresp=SLVERR (1).
  - Out-of-range read: rdata=0, rresp=SLVERR (1).
  - Handshake timing is unchanged.
- Undefined:
  - No range check; the upper address bits are dropped, so addresses alias modulo NUM_REGS*8.
  - bresp and rresp are always OKAY (0).

Decomposition:
- Package `crossbar` additions:
  - AXIL_DATA_W=64, AXIL_STRB_W=8.
  - AXIL_RESP_OKAY=1'b0, AXIL_RESP_SLVERR=1'b1.
  - typedef enum of write states {W_IDLE, W_RESP} and read states {R_IDLE, R_RESP}.
- One sub-module, axi4lite_strb_merge:
  - combinational old/new 64-bit merge under an 8-bit strobe.
  - reused later by other crossbar targets.

Test Plan:
- Reset release, no traffic -> awready=wready=arready=1, bvalid=rvalid=0, regs_o all = RESET_VAL.
- AW addr 0x10 and W data 0x1122334455667788, strb 0xFF in the same cycle, bready=1 -> bvalid the next cycle, bresp=0. Then read 0x10 -> rdata=0x1122334455667788 one cycle after AR.
- W first (data 0xAAAA..., strb 0x0F), AW at 0x10 three cycles later -> commit on the AW edge; reg2 = 0x11223344AAAAAAAA.
- bready held low 5 cycles -> bvalid/bresp stable; new AW held off (awready=0) until the B handshake completes.
- Same-edge write to 0x18 (new 0x5) and read of 0x18 (old 0x0) -> rdata=0x0; a later read returns 0x5.
- With AXIL_REG_SLVERR_EN, write to 0x40 (NUM_REGS=8) -> bresp=1, regs unchanged, and a read of 0x40 returns rresp=1, rdata=0. Without the macro, the same write lands in reg0 (alias).
